// File: rtl/wdgrv_pkg.sv
// wdgrv_pkg: shared state type and default widths for the WdgRV watchdog core
package wdgrv_pkg;
    localparam int WDGRV_CNT_WIDTH   = 32;
    localparam int WDGRV_TOCNT_WIDTH = 10;
    typedef enum logic [1:0] {IDLE, STAGE1, STAGE2, EXPIRED} wdgrv_state_e;
endpackage

// File: rtl/wdgrv_prescaler.sv
// wdgrv_prescaler: divides the clock into one-cycle ticks for the watchdog stages
//   i_clk   : clock
//   i_rst   : synchronous active-high reset
//   i_clear : restart the division from zero
//   i_run   : count only while a stage is active
//   o_tick  : one-cycle pulse on the last cycle of each period
module wdgrv_prescaler #(
    parameter int PRESCALE_DIV = 1024
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_clear,
    input  logic i_run,
    output logic o_tick
);
    localparam int PW = $clog2(PRESCALE_DIV);
    logic [PW-1:0] pcnt_q, pcnt_d;
    always_comb begin
        o_tick = i_run && (pcnt_q == PW'(PRESCALE_DIV - 1));
        pcnt_d = i_clear ? '0 : !i_run ? pcnt_q : o_tick ? '0 : pcnt_q + 1'b1;
    end
    always_ff @(posedge i_clk) begin
        if (i_rst) pcnt_q <= '0;
        else       pcnt_q <= pcnt_d;
    end
endmodule

// File: rtl/wdgrv_core.sv
// wdgrv_core: two-stage watchdog engine (stage 1 -> interrupt, stage 2 -> reset request)
//   i_clk, i_rst      : clock, synchronous active-high reset
//   i_wden            : watchdog enable
//   i_wtocnt          : per-stage timeout compare value, used live
//   i_kick            : software refresh pulse
//   o_cnt             : registered stage count
//   o_s1wto_hw_set    : one-cycle pulse when stage 1 expires
//   o_s2wto_hw_set    : one-cycle pulse when stage 2 expires
//   o_irq             : stage 1 expired and not yet kicked
//   o_reset_req       : stage 2 expired
// Optional: define WDGRV_CORE_PRESCALER_EN to advance the count once every
// PRESCALE_DIV cycles instead of every cycle.
module wdgrv_core import wdgrv_pkg::*; #(
    parameter int CNT_WIDTH    = WDGRV_CNT_WIDTH,
    parameter int TOCNT_WIDTH  = WDGRV_TOCNT_WIDTH,
    parameter int PRESCALE_DIV = 1024
) (
    input  logic                   i_clk,
    input  logic                   i_rst,
    input  logic                   i_wden,
    input  logic [TOCNT_WIDTH-1:0] i_wtocnt,
    input  logic                   i_kick,
    output logic [CNT_WIDTH-1:0]   o_cnt,
    output logic                   o_s1wto_hw_set,
    output logic                   o_s2wto_hw_set,
    output logic                   o_irq,
    output logic                   o_reset_req
);
    if (PRESCALE_DIV < 2) begin : g_div_check
        $error("PRESCALE_DIV must be at least 2");
    end

    wdgrv_state_e         state_q, state_d;
    logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
    logic                 s1_set_q, s1_set_d;
    logic                 s2_set_q, s2_set_d;
    logic                 irq_q, irq_d;
    logic                 reset_req_q, reset_req_d;
    logic                 tick, in_stage, timeout;

    assign in_stage = (state_q == STAGE1) || (state_q == STAGE2);
    assign timeout  = tick && (cnt_q >= CNT_WIDTH'(i_wtocnt));

`ifdef WDGRV_CORE_PRESCALER_EN
    // Any kick, stage change or disable restarts the tick period.
    wdgrv_prescaler #(.PRESCALE_DIV(PRESCALE_DIV)) u_prescaler (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_clear ((state_d != state_q) || i_kick || !i_wden),
        .i_run   (in_stage),
        .o_tick  (tick)
    );
`else
    assign tick = 1'b1;
`endif

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        s1_set_d    = 1'b0;
        s2_set_d    = 1'b0;
        irq_d       = irq_q;
        reset_req_d = reset_req_q;
        if (!i_wden) begin
            state_d     = IDLE;
            cnt_d       = '0;
            irq_d       = 1'b0;
            reset_req_d = 1'b0;
        end else if (state_q == IDLE) begin
            state_d = STAGE1;
            cnt_d   = '0;
        end else if (in_stage && i_kick) begin
            state_d = STAGE1;
            cnt_d   = '0;
            irq_d   = 1'b0;
        end else if (in_stage && timeout) begin
            cnt_d = '0;
            if (state_q == STAGE1) begin
                state_d  = STAGE2;
                s1_set_d = 1'b1;
                irq_d    = 1'b1;
            end else begin
                state_d     = EXPIRED;
                s2_set_d    = 1'b1;
                reset_req_d = 1'b1;
            end
        end else if (in_stage && tick) begin
            cnt_d = (cnt_q == '1) ? cnt_q : cnt_q + 1'b1;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            s1_set_q    <= 1'b0;
            s2_set_q    <= 1'b0;
            irq_q       <= 1'b0;
            reset_req_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            s1_set_q    <= s1_set_d;
            s2_set_q    <= s2_set_d;
            irq_q       <= irq_d;
            reset_req_q <= reset_req_d;
        end
    end

    assign o_cnt          = cnt_q;
    assign o_s1wto_hw_set = s1_set_q;
    assign o_s2wto_hw_set = s2_set_q;
    assign o_irq          = irq_q;
    assign o_reset_req    = reset_req_q;
endmodule
